// File: rtl/byte_manip_seq.sv
// byte_manip_seq: registered byte move/swap/sign-extend unit with multi-cycle byte reverse and rotate
module byte_manip_seq #(
  parameter int DATA_W = 16,
  localparam int NBYTES = DATA_W / 8,
  localparam int LANE_W = $clog2(NBYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] dst_in,
  input  logic [7:0]        byte_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dst_out,
  output logic              busy
);
  localparam int CW = LANE_W + 1;
  typedef enum logic [2:0] {MOVL, MOVLZ, MOVLS, MOVH, SWPB, REVB, ROTB, SXTB} op_e;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;
  if (DATA_W % 8 != 0 || DATA_W < 16) begin : g_bad_width
    $error("byte_manip_seq: DATA_W must be a multiple of 8 and >= 16");
  end
  state_e state, nxt_state;
  logic [DATA_W-1:0] work, nxt_work, nxt_out, single, first, step;
  logic [CW-1:0] cnt, nxt_cnt;
  logic is_rev, nxt_rev;
  logic [7:0] sel;
  int ln, steps, pj;
  function automatic logic [DATA_W-1:0] swap_b(input logic [DATA_W-1:0] w, input int a, input int b);
    logic [DATA_W-1:0] r;
    r = w;
    r[8*a +: 8] = w[8*b +: 8];
    r[8*b +: 8] = w[8*a +: 8];
    return r;
  endfunction
  function automatic logic [DATA_W-1:0] rot(input logic [DATA_W-1:0] w);
    return {w[DATA_W-9:0], w[DATA_W-1 -: 8]};
  endfunction
  assign ln = (int'(lane) >= NBYTES) ? NBYTES - 1 : int'(lane);
  assign sel = dst_in[8*ln +: 8];
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == HOLD;
  assign busy = state != IDLE;
  assign steps = op == REVB ? NBYTES / 2 : ln;
  // REVB starts at the innermost pair on accept and works outwards as cnt counts down
  assign first = op == REVB ? swap_b(dst_in, NBYTES / 2 - 1, NBYTES - NBYTES / 2) : rot(dst_in);
  assign pj = cnt == '0 ? 0 : int'(cnt) - 1;
  assign step = is_rev ? swap_b(work, pj, NBYTES - 1 - pj) : rot(work);
  always_comb begin
    case (op)
      MOVL:    single = {dst_in[DATA_W-1:8], byte_val};
      MOVLZ:   single = {{(DATA_W-8){1'b0}}, byte_val};
      MOVLS:   single = {{(DATA_W-8){1'b1}}, byte_val};
      MOVH:    single = {byte_val, dst_in[DATA_W-9:0]};
      SWPB:    single = swap_b(dst_in, 0, ln);
      default: single = {{(DATA_W-8){sel[7]}}, sel};
    endcase
  end
  always_comb begin
    nxt_state = state;
    nxt_out = dst_out;
    nxt_work = work;
    nxt_cnt = cnt;
    nxt_rev = is_rev;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        nxt_rev = op == REVB;
        if ((op == REVB || op == ROTB) && steps != 0) begin
          nxt_work = first;
          nxt_cnt = CW'(steps - 1);
          nxt_out = steps == 1 ? first : dst_out;
          nxt_state = steps == 1 ? HOLD : EXEC;
        end else begin
          nxt_out = op == ROTB ? dst_in : single;
          nxt_state = HOLD;
        end
      end
      EXEC: begin
        nxt_work = step;
        nxt_cnt = cnt - CW'(1);
        nxt_out = cnt == CW'(1) ? step : dst_out;
        nxt_state = cnt == CW'(1) ? HOLD : EXEC;
      end
      HOLD: nxt_state = out_ready ? IDLE : HOLD;
      default: nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dst_out <= '0;
      work <= '0;
      cnt <= '0;
      is_rev <= 1'b0;
    end else begin
      state <= nxt_state;
      dst_out <= nxt_out;
      work <= nxt_work;
      cnt <= nxt_cnt;
      is_rev <= nxt_rev;
    end
  end
endmodule

// File: tb/tb_byte_manip_seq.sv
// tb_byte_manip_seq: scoreboard bench driving 16/32/64-bit instances of byte_manip_seq
module tb_byte_manip_seq;
  typedef struct { int u; logic [63:0] v; string nm; } exp_t;
  localparam logic [2:0] MOVL = 0, MOVLZ = 1, MOVLS = 2, MOVH = 3, SWPB = 4, REVB = 5, ROTB = 6, SXTB = 7;
  logic clk = 0, rst = 1;
  logic [2:0] iv = 0, ordy = 0;
  wire [2:0] ov, irdy, bsy;
  logic [2:0] opc [3];
  logic [2:0] ln [3];
  logic [63:0] din [3];
  logic [7:0] bv [3];
  wire [15:0] d16;
  wire [31:0] d32;
  wire [63:0] d64;
  logic [63:0] dout [3];
  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    dout[0] = {48'b0, d16};
    dout[1] = {32'b0, d32};
    dout[2] = d64;
  end

  byte_manip_seq #(.DATA_W(16)) u16 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .op(opc[0]),
    .lane(ln[0][0:0]), .dst_in(din[0][15:0]), .byte_val(bv[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .dst_out(d16), .busy(bsy[0]));
  byte_manip_seq #(.DATA_W(32)) u32 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .op(opc[1]),
    .lane(ln[1][1:0]), .dst_in(din[1][31:0]), .byte_val(bv[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .dst_out(d32), .busy(bsy[1]));
  byte_manip_seq #(.DATA_W(64)) u64 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .op(opc[2]),
    .lane(ln[2]), .dst_in(din[2]), .byte_val(bv[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .dst_out(d64), .busy(bsy[2]));

  always @(negedge clk)
    for (int u = 0; u < 3; u++)
      if (ov[u] && ordy[u]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output unit %0d got %h", u, dout[u]);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.u != u || dout[u] !== mon_e.v) begin
            errors++;
            $display("FAIL %s unit %0d got %h expected %h (unit %0d)", mon_e.nm, u, dout[u], mon_e.v, mon_e.u);
          end
        end
      end

  task automatic send(input int u, input logic [2:0] o, input logic [2:0] l, input logic [63:0] d,
                      input logic [7:0] b, input logic [63:0] e, input int lat, input string nm);
    int n;
    @(negedge clk);
    checks++;
    if (irdy[u] !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b expected 1", nm, irdy[u]); end
    opc[u] = o; ln[u] = l; din[u] = d; bv[u] = b; iv[u] = 1; ordy[u] = 1;
    q.push_back('{u, e, nm});
    @(posedge clk);
    #1 iv[u] = 0; din[u] = ~d; bv[u] = ~b;
    checks++;
    if (bsy[u] !== 1'b1) begin errors++; $display("FAIL %s_busy got %b expected 1", nm, bsy[u]); end
    n = 1;
    while (!ov[u] && n < 20) begin @(posedge clk); #1 n++; end
    checks++;
    if (n != lat) begin errors++; $display("FAIL %s_latency got %0d expected %0d", nm, n, lat); end
    @(posedge clk);
    #1;
    checks++;
    if (ov[u] !== 1'b0 || irdy[u] !== 1'b1 || bsy[u] !== 1'b0 || dout[u] !== e) begin
      errors++;
      $display("FAIL %s_idle got ov=%b rdy=%b busy=%b dout=%h expected 0 1 0 %h", nm, ov[u], irdy[u], bsy[u], dout[u], e);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (ov[u] !== 0 || bsy[u] !== 0 || irdy[u] !== 0 || dout[u] !== 0) begin
        errors++;
        $display("FAIL reset unit %0d got ov=%b busy=%b rdy=%b dout=%h expected 0 0 0 0", u, ov[u], bsy[u], irdy[u], dout[u]);
      end
    end
    rst = 0;
    #1;
    checks++;
    if (irdy !== 3'b111) begin errors++; $display("FAIL reset_release in_ready got %b expected 111", irdy); end
  endtask

  task automatic test_ops16;
    send(0, MOVLZ, 0, 64'hABCD, 8'h12, 64'h0012, 1, "movlz16");
    send(0, MOVLS, 0, 64'h00CD, 8'h80, 64'hFF80, 1, "movls16");
    send(0, MOVH, 0, 64'h1234, 8'h5A, 64'h5A34, 1, "movh16");
    send(0, SWPB, 1, 64'hABCD, 8'h00, 64'hCDAB, 1, "swpb16");
    send(0, SWPB, 0, 64'hABCD, 8'h00, 64'hABCD, 1, "swpb16_l0");
    send(0, MOVL, 0, 64'hABCD, 8'h77, 64'hAB77, 1, "movl16");
    send(0, REVB, 0, 64'hABCD, 8'h00, 64'hCDAB, 1, "revb16");
    send(0, ROTB, 1, 64'hABCD, 8'h00, 64'hCDAB, 1, "rotb16");
    send(0, SXTB, 1, 64'h80CD, 8'h00, 64'hFF80, 1, "sxtb16");
  endtask

  task automatic test_multi32;
    send(1, REVB, 0, 64'h11223344, 8'h00, 64'h44332211, 2, "revb32");
    send(1, ROTB, 3, 64'h11223344, 8'h00, 64'h44112233, 3, "rotb32_l3");
    send(1, ROTB, 0, 64'h11223344, 8'h00, 64'h11223344, 1, "rotb32_l0");
    send(1, ROTB, 1, 64'h11223344, 8'h00, 64'h22334411, 1, "rotb32_l1");
  endtask

  task automatic test_sxtb32;
    send(1, SXTB, 1, 64'h00008000, 8'h00, 64'hFFFFFF80, 1, "sxtb32_l1");
    send(1, SXTB, 0, 64'h0000807F, 8'h00, 64'h0000007F, 1, "sxtb32_l0");
    send(1, SWPB, 3, 64'h11223344, 8'h00, 64'h44223311, 1, "swpb32_l3");
    send(1, MOVH, 0, 64'h11223344, 8'hAA, 64'hAA223344, 1, "movh32");
  endtask

  task automatic test_wide64;
    send(2, REVB, 0, 64'h0102030405060708, 8'h00, 64'h0807060504030201, 4, "revb64");
    send(2, ROTB, 7, 64'h0102030405060708, 8'h00, 64'h0801020304050607, 7, "rotb64_l7");
    send(2, SWPB, 5, 64'h0102030405060708, 8'h00, 64'h0102080405060703, 1, "swpb64");
    send(2, MOVLS, 0, 64'h0102030405060708, 8'h55, 64'hFFFFFFFFFFFFFF55, 1, "movls64");
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [1:0] l;
    logic [31:0] e;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      l = 2'($urandom_range(0, 3));
      e = l == 0 ? d : (d << (8 * l)) | (d >> (32 - 8 * l));
      send(1, ROTB, {1'b0, l}, {32'b0, d}, 8'h00, {32'b0, e}, l == 0 ? 1 : int'(l), "rotb32_rand");
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    opc[0] = MOVL; ln[0] = 0; din[0] = 64'h1234; bv[0] = 8'hAB; iv[0] = 1; ordy[0] = 0;
    q.push_back('{0, 64'h12AB, "hold"});
    @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b1) begin errors++; $display("FAIL hold_valid got %b expected 1", ov[0]); end
    for (int i = 0; i < 5; i++) begin
      din[0] = ~din[0]; bv[0] = ~bv[0];
      @(posedge clk);
      #1;
      checks++;
      if (dout[0] !== 64'h12AB || irdy[0] !== 1'b0 || ov[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable got dout=%h rdy=%b ov=%b expected 12ab 0 1", dout[0], irdy[0], ov[0]);
      end
    end
    ordy[0] = 1;
    @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got ov=%b rdy=%b expected 0 1", ov[0], irdy[0]);
    end
    iv[0] = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    opc[2] = REVB; din[2] = 64'h1122334455667788; iv[2] = 1; ordy[2] = 1;
    @(posedge clk);
    #1 iv[2] = 0;
    checks++;
    if (bsy[2] !== 1'b1 || ov[2] !== 1'b0) begin errors++; $display("FAIL midrst_exec got busy=%b ov=%b expected 1 0", bsy[2], ov[2]); end
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    checks++;
    if (ov[2] !== 0 || dout[2] !== 0 || bsy[2] !== 0 || irdy[2] !== 0) begin
      errors++;
      $display("FAIL midrst_state got ov=%b dout=%h busy=%b rdy=%b expected 0 0 0 0", ov[2], dout[2], bsy[2], irdy[2]);
    end
    rst = 0;
    #1;
    checks++;
    if (irdy[2] !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b expected 1", irdy[2]); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ov[2] !== 1'b0 || dout[2] !== 0) begin errors++; $display("FAIL midrst_residue got ov=%b dout=%h expected 0 0", ov[2], dout[2]); end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin opc[u] = 0; ln[u] = 0; din[u] = 0; bv[u] = 0; end
    test_reset;
    test_ops16;
    test_multi32;
    test_sxtb32;
    test_wide64;
    test_back_to_back;
    test_hold;
    test_reset_mid;
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending expected 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
